// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 32-bit three-port register file with load-pending scoreboard
//
// Purpose: two combinational read ports with write-first bypass, one writeback
// port, and a per-register pending bit that flags operands still waiting on an
// outstanding multi-cycle load.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous, active-high; clears regs and pend
//   readreg1, readreg2   read addresses for operand 1 / operand 2
//   dataout1, dataout2   combinational read data
//   regwrite             writeback enable
//   writereg, writedata  writeback address / data
//   issue_valid          a load to issue_reg is issued this cycle
//   issue_reg            destination of the issued load
//   hazard1, hazard2     operand register has an outstanding load
module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  output logic [WIDTH-1:0]  dataout1,
  output logic [WIDTH-1:0]  dataout2,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [WIDTH-1:0]  writedata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              hazard1,
  output logic              hazard2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;

  // Clear is applied before set so that an issue and a writeback to the same
  // register in one cycle leaves it pending: the writeback belongs to an
  // older producer. Register 0 is never set.
  always_comb begin
    pend_next = pend;
    if (regwrite) begin
      pend_next[writereg] = 1'b0;
    end
    if (issue_valid && (issue_reg != '0)) begin
      pend_next[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      if (regwrite && (writereg != '0)) begin
        regs[writereg] <= writedata;
      end
      pend <= pend_next;
    end
  end

  logic byp1;
  logic byp2;

  assign byp1 = regwrite && (writereg == readreg1);
  assign byp2 = regwrite && (writereg == readreg2);

  // Reset also masks the bypass path, so reads are zero for the whole time
  // reset is held, not just after the first edge.
  always_comb begin
    dataout1 = '0;
    if (!reset && (readreg1 != '0)) begin
      dataout1 = byp1 ? writedata : regs[readreg1];
    end
  end

  always_comb begin
    dataout2 = '0;
    if (!reset && (readreg2 != '0)) begin
      dataout2 = byp2 ? writedata : regs[readreg2];
    end
  end

  // A writeback in the same cycle resolves the hazard through the bypass.
  assign hazard1 = !reset && pend[readreg1] && !byp1;
  assign hazard2 = !reset && pend[readreg2] && !byp2;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readreg1, readreg2, writereg, issue_reg;
  logic [31:0] dataout1, dataout2, writedata;
  logic        regwrite, issue_valid;
  logic        hazard1, hazard2;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .reset(reset),
    .readreg1(readreg1), .readreg2(readreg2),
    .dataout1(dataout1), .dataout2(dataout2),
    .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .hazard1(hazard1), .hazard2(hazard2)
  );

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (reset || a == 0) return 32'h0;
    if (regwrite && writereg == a) return writedata;
    return m_regs[a];
  endfunction

  function automatic logic exp_haz(input logic [4:0] a);
    if (reset) return 1'b0;
    return m_pend[a] && !(regwrite && writereg == a);
  endfunction

  task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                       input logic iv, input logic [4:0] ir,
                       input logic [4:0] r1, input logic [4:0] r2);
    regwrite = rw; writereg = wr; writedata = wd;
    issue_valid = iv; issue_reg = ir;
    readreg1 = r1; readreg2 = r2;
    #1;
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (regwrite && writereg != 0) m_regs[writereg] = writedata;
      if (regwrite) m_pend[writereg] = 1'b0;
      if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    drive(1, 5'd4, 32'hFFFF_FFFF, 1, 5'd4, 5'd4, 5'd4);
    checks++;
    if (dataout1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_bypass_masked: got %h expected %h", dataout1, 32'h0);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'(i), 5'(31 - i));
      checks++;
      if (dataout1 !== 32'h0 || dataout2 !== 32'h0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_state r%0d: got d1=%h d2=%h h1=%b h2=%b expected all zero",
                 i, dataout1, dataout2, hazard1, hazard2);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd0);
    checks++;
    if (dataout1 !== 32'hDEAD_BEEF || dataout2 !== 32'h0) begin
      failures++;
      $display("FAIL write_read_r5: got d1=%h d2=%h expected d1=deadbeef d2=0", dataout1, dataout2);
    end
    drive(1, 5'd0, 32'h1234_5678, 0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (dataout1 !== 32'h0) begin
      failures++;
      $display("FAIL r0_bypass: got %h expected %h", dataout1, 32'h0);
    end
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (dataout1 !== 32'h0 || dataout2 !== 32'h0) begin
      failures++;
      $display("FAIL r0_write_ignored: got d1=%h d2=%h expected 0", dataout1, dataout2);
    end
  endtask

  task automatic test_bypass();
    drive(1, 5'd7, 32'h1, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd7);
    checks++;
    if (dataout1 !== 32'h1) begin
      failures++;
      $display("FAIL bypass_pre: got %h expected %h", dataout1, 32'h1);
    end
    drive(1, 5'd7, 32'hA5A5_A5A5, 0, 5'd0, 5'd7, 5'd7);
    checks++;
    if (dataout1 !== 32'hA5A5_A5A5 || dataout2 !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL bypass_same_cycle: got d1=%h d2=%h expected a5a5a5a5", dataout1, dataout2);
    end
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd7, 5'd0);
    checks++;
    if (dataout1 !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL bypass_after: got %h expected %h", dataout1, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_hazard();
    drive(0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
    checks++;
    if (hazard1 !== 1'b0) begin
      failures++;
      $display("FAIL hazard_issue_cycle: got %b expected 0", hazard1);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd9);
      checks++;
      if (hazard1 !== 1'b1 || hazard2 !== 1'b1) begin
        failures++;
        $display("FAIL hazard_wait c%0d: got h1=%b h2=%b expected 1", c, hazard1, hazard2);
      end
      tick();
    end
    drive(1, 5'd9, 32'h55, 0, 5'd0, 5'd9, 5'd0);
    checks++;
    if (hazard1 !== 1'b0 || dataout1 !== 32'h55) begin
      failures++;
      $display("FAIL hazard_writeback: got h1=%b d1=%h expected h1=0 d1=55", hazard1, dataout1);
    end
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
    checks++;
    if (hazard1 !== 1'b0 || dataout1 !== 32'h55) begin
      failures++;
      $display("FAIL hazard_after: got h1=%b d1=%h expected h1=0 d1=55", hazard1, dataout1);
    end
  endtask

  task automatic test_set_wins();
    drive(1, 5'd3, 32'h33, 1, 5'd3, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd0);
    checks++;
    if (hazard1 !== 1'b1) begin
      failures++;
      $display("FAIL set_wins: got %b expected 1", hazard1);
    end
    drive(1, 5'd3, 32'h34, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
      checks++;
      if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
        failures++;
        $display("FAIL issue_r0 c%0d: got h1=%b h2=%b expected 0", c, hazard1, hazard2);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(1, 5'd12, 32'hCAFE_0012, 1, 5'd12, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd0);
    checks++;
    if (hazard1 !== 1'b1 || dataout1 !== 32'hCAFE_0012) begin
      failures++;
      $display("FAIL async_pre: got h1=%b d1=%h expected h1=1 d1=cafe0012", hazard1, dataout1);
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    checks++;
    if (hazard1 !== 1'b0 || dataout1 !== 32'h0) begin
      failures++;
      $display("FAIL async_immediate: got h1=%b d1=%h expected 0", hazard1, dataout1);
    end
    tick();
    reset = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd12);
    checks++;
    if (hazard1 !== 1'b0 || dataout1 !== 32'h0) begin
      failures++;
      $display("FAIL async_after: got h1=%b d1=%h expected 0", hazard1, dataout1);
    end
    drive(1, 5'd12, 32'h77, 0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd0);
    checks++;
    if (hazard1 !== 1'b0 || dataout1 !== 32'h77) begin
      failures++;
      $display("FAIL async_late_wb: got h1=%b d1=%h expected h1=0 d1=77", hazard1, dataout1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      checks++;
      if (dataout1 !== exp_data(readreg1) || dataout2 !== exp_data(readreg2) ||
          hazard1 !== exp_haz(readreg1) || hazard2 !== exp_haz(readreg2)) begin
        failures++;
        $display("FAIL random c%0d: got d1=%h d2=%h h1=%b h2=%b expected d1=%h d2=%h h1=%b h2=%b",
                 c, dataout1, dataout2, hazard1, hazard2,
                 exp_data(readreg1), exp_data(readreg2), exp_haz(readreg1), exp_haz(readreg2));
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_hazard();
    test_set_wins();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
